// File: rtl/tile_obi_demux_pkg.sv
// Shared constants and types for the tile's OBI data-port demultiplexer.
// Address rules are {idx, start_addr, end_addr}; end_addr is exclusive.
package tile_obi_demux_pkg;

    localparam int TILE_ADDR_W     = 32;
    localparam int TILE_DATA_W     = 32;
    localparam int TILE_AID_W      = 1;
    localparam int TILE_N_MAX_TRAN = 4;

    localparam logic [31:0] TILE_ERR_RDATA = 32'hBADC_AB1E;

    typedef struct packed {
        logic [31:0]            idx;
        logic [TILE_ADDR_W-1:0] start_addr;
        logic [TILE_ADDR_W-1:0] end_addr;
    } addr_rule_t;

    // Range test only; whether idx names a real subordinate is checked by the caller.
    function automatic logic addr_in_rule(input addr_rule_t rule,
                                          input logic [TILE_ADDR_W-1:0] addr);
        return (addr >= rule.start_addr) && (addr < rule.end_addr);
    endfunction

endpackage

// File: rtl/tile_obi_demux_if.sv
// Manager-side and subordinate-side OBI signals of the demux, bundled.
// The demux uses the slave modport; the environment driving it uses master.
interface tile_obi_demux_if
    import tile_obi_demux_pkg::*;
#(
    parameter int N_SBR  = 2,
    parameter int ADDR_W = TILE_ADDR_W,
    parameter int DATA_W = TILE_DATA_W,
    parameter int AID_W  = TILE_AID_W
);
    localparam int BE_W = DATA_W / 8;

    logic                          mgr_req_i;
    logic                          mgr_gnt_o;
    logic [ADDR_W-1:0]             mgr_addr_i;
    logic                          mgr_we_i;
    logic [BE_W-1:0]               mgr_be_i;
    logic [DATA_W-1:0]             mgr_wdata_i;
    logic [AID_W-1:0]              mgr_aid_i;
    logic                          mgr_rvalid_o;
    logic [DATA_W-1:0]             mgr_rdata_o;
    logic                          mgr_err_o;
    logic [AID_W-1:0]              mgr_rid_o;

    logic [N_SBR-1:0]              sbr_req_o;
    logic [N_SBR-1:0]              sbr_gnt_i;
    logic [N_SBR-1:0][ADDR_W-1:0]  sbr_addr_o;
    logic [N_SBR-1:0]              sbr_we_o;
    logic [N_SBR-1:0][BE_W-1:0]    sbr_be_o;
    logic [N_SBR-1:0][DATA_W-1:0]  sbr_wdata_o;
    logic [N_SBR-1:0][AID_W-1:0]   sbr_aid_o;
    logic [N_SBR-1:0]              sbr_rvalid_i;
    logic [N_SBR-1:0][DATA_W-1:0]  sbr_rdata_i;
    logic [N_SBR-1:0]              sbr_err_i;
    logic [N_SBR-1:0][AID_W-1:0]   sbr_rid_i;

    modport slave (
        input  mgr_req_i, mgr_addr_i, mgr_we_i, mgr_be_i, mgr_wdata_i, mgr_aid_i,
        output mgr_gnt_o, mgr_rvalid_o, mgr_rdata_o, mgr_err_o, mgr_rid_o,
        output sbr_req_o, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o, sbr_aid_o,
        input  sbr_gnt_i, sbr_rvalid_i, sbr_rdata_i, sbr_err_i, sbr_rid_i
    );

    modport master (
        output mgr_req_i, mgr_addr_i, mgr_we_i, mgr_be_i, mgr_wdata_i, mgr_aid_i,
        input  mgr_gnt_o, mgr_rvalid_o, mgr_rdata_o, mgr_err_o, mgr_rid_o,
        input  sbr_req_o, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o, sbr_aid_o,
        output sbr_gnt_i, sbr_rvalid_i, sbr_rdata_i, sbr_err_i, sbr_rid_i
    );

endinterface

// File: rtl/tile_obi_err_sbr.sv
// Error subordinate for unmapped addresses: always grants, and answers every
// grant one cycle later with err=1, a fixed rdata and the captured aid.
module tile_obi_err_sbr
    import tile_obi_demux_pkg::*;
#(
    parameter int                AID_W     = TILE_AID_W,
    parameter int                DATA_W    = TILE_DATA_W,
    parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(TILE_ERR_RDATA)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [AID_W-1:0]  aid_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [AID_W-1:0]  rid_o
);

    logic             rvalid_q, rvalid_d;
    logic [AID_W-1:0] rid_q, rid_d;

    // Grant is unconditional, so req_i here is already a completed handshake.
    always_comb begin
        rvalid_d = req_i;
        rid_d    = rid_q;
        if (req_i) begin
            rid_d = aid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rid_q    <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
        end
    end

    assign gnt_o    = 1'b1;
    assign rvalid_o = rvalid_q;
    assign err_o    = rvalid_q;
    assign rdata_o  = rvalid_q ? ERR_RDATA : '0;
    assign rid_o    = rvalid_q ? rid_q : '0;

endmodule

// File: rtl/tile_obi_demux.sv
// Single-manager to N_SBR-subordinate OBI demux with runtime address rules,
// in-order responses and an internal error subordinate for unmapped accesses.
module tile_obi_demux
    import tile_obi_demux_pkg::*;
#(
    parameter int                N_SBR       = 2,
    parameter int                N_ADDR_RULE = 2,
    parameter int                N_MAX_TRAN  = TILE_N_MAX_TRAN,
    parameter int                ADDR_W      = TILE_ADDR_W,
    parameter int                DATA_W      = TILE_DATA_W,
    parameter int                AID_W       = TILE_AID_W,
    parameter logic [DATA_W-1:0] ERR_RDATA   = DATA_W'(TILE_ERR_RDATA)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    // Rule addresses are TILE_ADDR_W wide, so ADDR_W is expected to match it.
    input  addr_rule_t [N_ADDR_RULE-1:0]     addr_map_i,
    tile_obi_demux_if.slave                  bus
);

    localparam int               SEL_W   = $clog2(N_SBR + 1);
    localparam int               CNT_W   = $clog2(N_MAX_TRAN + 1);
    localparam logic [SEL_W-1:0] ERR_SEL = SEL_W'(N_SBR);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_MAX_TRAN);

    logic [SEL_W-1:0]       cur_sel_q, cur_sel_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [N_ADDR_RULE-1:0] rule_hit;
    logic [SEL_W-1:0]       target;
    logic                   tgt_gnt;
    logic                   allowed;
    logic                   handshake;

    logic                   sel_rvalid;
    logic                   sel_err;
    logic [DATA_W-1:0]      sel_rdata;
    logic [AID_W-1:0]       sel_rid;
    logic                   rsp_fire;
    logic                   stray;

    logic                   err_req;
    logic                   err_gnt;
    logic                   err_rvalid;
    logic                   err_err;
    logic [DATA_W-1:0]      err_rdata;
    logic [AID_W-1:0]       err_rid;

    // Decode: rules naming a non-existent subordinate never hit.
    for (genvar gi = 0; gi < N_ADDR_RULE; gi++) begin : g_rule
        assign rule_hit[gi] = (addr_map_i[gi].idx < 32'(N_SBR))
                            && addr_in_rule(addr_map_i[gi], bus.mgr_addr_i);
    end

    // Walk from the highest rule down so the lowest-index hit has the last word.
    always_comb begin
        target = ERR_SEL;
        for (int r = N_ADDR_RULE - 1; r >= 0; r--) begin
            if (rule_hit[r]) begin
                target = addr_map_i[r].idx[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        tgt_gnt = err_gnt;
        for (int i = 0; i < N_SBR; i++) begin
            if (target == SEL_W'(i)) begin
                tgt_gnt = bus.sbr_gnt_i[i];
            end
        end
    end

    always_comb begin
        sel_rvalid = err_rvalid;
        sel_err    = err_err;
        sel_rdata  = err_rdata;
        sel_rid    = err_rid;
        for (int i = 0; i < N_SBR; i++) begin
            if (cur_sel_q == SEL_W'(i)) begin
                sel_rvalid = bus.sbr_rvalid_i[i];
                sel_err    = bus.sbr_err_i[i];
                sel_rdata  = bus.sbr_rdata_i[i];
                sel_rid    = bus.sbr_rid_i[i];
            end
        end
    end

    always_comb begin
        stray = 1'b0;
        for (int i = 0; i < N_SBR; i++) begin
            if (bus.sbr_rvalid_i[i] && ((cur_sel_q != SEL_W'(i)) || (cnt_q == '0))) begin
                stray = 1'b1;
            end
        end
    end

    assign rsp_fire = sel_rvalid && (cnt_q != '0) && !rst_i;

    // A response retiring this cycle frees its slot for another request to the same target.
    assign allowed   = (cnt_q == '0)
                     || ((target == cur_sel_q) && ((cnt_q != CNT_MAX) || rsp_fire));
    assign handshake = bus.mgr_req_i && bus.mgr_gnt_o;
    assign err_req   = bus.mgr_req_i && allowed && (target == ERR_SEL);

    assign bus.mgr_gnt_o    = allowed && tgt_gnt;
    assign bus.mgr_rvalid_o = rsp_fire;
    assign bus.mgr_err_o    = rsp_fire && sel_err;
    assign bus.mgr_rdata_o  = rsp_fire ? sel_rdata : '0;
    assign bus.mgr_rid_o    = rsp_fire ? sel_rid : '0;

    for (genvar gi = 0; gi < N_SBR; gi++) begin : g_sbr
        assign bus.sbr_req_o[gi]   = bus.mgr_req_i && allowed && (target == SEL_W'(gi));
        assign bus.sbr_addr_o[gi]  = bus.mgr_addr_i;
        assign bus.sbr_we_o[gi]    = bus.mgr_we_i;
        assign bus.sbr_be_o[gi]    = bus.mgr_be_i;
        assign bus.sbr_wdata_o[gi] = bus.mgr_wdata_i;
        assign bus.sbr_aid_o[gi]   = bus.mgr_aid_i;
    end

    always_comb begin
        cur_sel_d = cur_sel_q;
        cnt_d     = cnt_q;
        if (handshake) begin
            cur_sel_d = target;
        end
        case ({handshake, rsp_fire})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_sel_q <= '0;
            cnt_q     <= '0;
        end else begin
            cur_sel_q <= cur_sel_d;
            cnt_q     <= cnt_d;
        end
    end

    tile_obi_err_sbr #(
        .AID_W     (AID_W),
        .DATA_W    (DATA_W),
        .ERR_RDATA (ERR_RDATA)
    ) u_err_sbr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (err_req),
        .aid_i    (bus.mgr_aid_i),
        .gnt_o    (err_gnt),
        .rvalid_o (err_rvalid),
        .err_o    (err_err),
        .rdata_o  (err_rdata),
        .rid_o    (err_rid)
    );

    // Stray responses are already masked above; this only flags them.
    a_no_stray : assert property (@(posedge clk_i) disable iff (rst_i) !stray)
        else $error("tile_obi_demux: stray subordinate response dropped");

    a_mgr_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.mgr_req_i && !bus.mgr_gnt_o) |=>
            (bus.mgr_req_i && $stable(bus.mgr_addr_i) && $stable(bus.mgr_we_i)
             && $stable(bus.mgr_be_i) && $stable(bus.mgr_wdata_i) && $stable(bus.mgr_aid_i)))
        else $error("tile_obi_demux: manager request changed before grant");

endmodule

// File: tb/tb_tile_obi_demux.sv
// Randomised bench for tile_obi_demux: a queue of in-flight transactions plus
// first-match rule decoding predicts grants, routing and every response.
module tb_tile_obi_demux;
    import tile_obi_demux_pkg::*;

    localparam int N_SBR       = 2;
    localparam int N_ADDR_RULE = 3;
    localparam int N_MAX_TRAN  = 4;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int AID_W       = 1;
    localparam int BE_W        = DATA_W / 8;
    localparam logic [31:0] ERR_RDATA = 32'hBADC_AB1E;

    typedef struct {
        int               tgt;
        logic [AID_W-1:0] aid;
        int               cyc;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    addr_rule_t [N_ADDR_RULE-1:0] rules;

    tile_obi_demux_if #(.N_SBR(N_SBR), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AID_W(AID_W)) bus ();

    tile_obi_demux #(
        .N_SBR(N_SBR), .N_ADDR_RULE(N_ADDR_RULE), .N_MAX_TRAN(N_MAX_TRAN),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AID_W(AID_W), .ERR_RDATA(ERR_RDATA)
    ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .addr_map_i (rules),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_txn   = 0;
    int cyc     = 0;
    txn_t inflight[$];

    logic              pend = 1'b0;
    logic [ADDR_W-1:0] p_addr = '0;
    logic              p_we = 1'b0;
    logic [BE_W-1:0]   p_be = '0;
    logic [DATA_W-1:0] p_wdata = '0;
    logic [AID_W-1:0]  p_aid = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Table 0: disjoint ranges. Table 1: rule 0 overlaps rule 1. Rule 2 names idx 5 in both.
    task automatic set_rules(input int table_sel);
        rules[0] = '{idx: 32'd0, start_addr: 32'h1000_0000,
                     end_addr: (table_sel == 0) ? 32'h2000_0000 : 32'h3000_0000};
        rules[1] = '{idx: 32'd1, start_addr: 32'h2000_0000, end_addr: 32'h3000_0000};
        rules[2] = '{idx: 32'd5, start_addr: 32'h4000_0000, end_addr: 32'h5000_0000};
    endtask

    function automatic int ref_target(input logic [ADDR_W-1:0] addr);
        for (int r = 0; r < N_ADDR_RULE; r++) begin
            if (rules[r].idx < N_SBR && addr >= rules[r].start_addr && addr < rules[r].end_addr)
                return int'(rules[r].idx);
        end
        return N_SBR;
    endfunction

    function automatic logic [ADDR_W-1:0] pick_addr(input int mode);
        logic [31:0] edges [9] = '{32'h1000_0000, 32'h1FFF_FFFF, 32'h2000_0000,
                                   32'h2FFF_FFFF, 32'h3000_0000, 32'h0FFF_FFFF,
                                   32'h4000_0000, 32'h4FFF_FFFF, 32'h5000_0000};
        int k;
        k = $urandom_range(3);
        case (mode)
            1:       return 32'h2000_0000 + ($urandom & 32'h0FFF_FFFC);
            2:       return (k == 0) ? 32'h1000_0040 : 32'h4000_0000 + ($urandom & 32'h1FFF_FFFC);
            default: begin
                if (k < 2)  return edges[$urandom_range(8)];
                if (k == 2) return 32'h1000_0000 + ($urandom & 32'h3FFF_FFFC);
                return $urandom;
            end
        endcase
    endfunction

    task automatic drive_idle();
        bus.mgr_req_i    = 1'b0;
        bus.mgr_addr_i   = p_addr;
        bus.mgr_we_i     = 1'b0;
        bus.mgr_be_i     = '0;
        bus.mgr_wdata_i  = '0;
        bus.mgr_aid_i    = '0;
        bus.sbr_gnt_i    = '0;
        bus.sbr_rvalid_i = '0;
        bus.sbr_rdata_i  = '0;
        bus.sbr_err_i    = '0;
        bus.sbr_rid_i    = '0;
    endtask

    // One clock cycle: drive at posedge+1, predict, compare at negedge, then retire/issue in the model.
    task automatic step(input int p_req, input int p_gnt, input int p_rsp, input int amode);
        int                tgt;
        logic              allowed, rsp_now, exp_gnt, exp_err;
        logic [N_SBR-1:0]  gnts, exp_req;
        logic [DATA_W-1:0] exp_rdata, r_data;
        logic [AID_W-1:0]  exp_rid;
        logic              r_err;
        txn_t              h;

        @(posedge clk); #1;
        if (!pend && $urandom_range(99) < p_req) begin
            pend    = 1'b1;
            p_addr  = pick_addr(amode);
            p_aid   = AID_W'($urandom);
            p_we    = 1'($urandom);
            p_be    = BE_W'($urandom);
            p_wdata = $urandom;
        end
        bus.mgr_req_i   = pend;
        bus.mgr_addr_i  = p_addr;
        bus.mgr_we_i    = p_we;
        bus.mgr_be_i    = p_be;
        bus.mgr_wdata_i = p_wdata;
        bus.mgr_aid_i   = p_aid;

        for (int i = 0; i < N_SBR; i++) begin
            gnts[i]            = ($urandom_range(99) < p_gnt);
            bus.sbr_rdata_i[i] = $urandom;
            bus.sbr_err_i[i]   = 1'($urandom);
            bus.sbr_rid_i[i]   = AID_W'($urandom);
        end
        bus.sbr_gnt_i    = gnts;
        bus.sbr_rvalid_i = '0;

        rsp_now = 1'b0; exp_err = 1'b0; exp_rdata = '0; exp_rid = '0;
        if (inflight.size() > 0) begin
            h = inflight[0];
            if (h.tgt == N_SBR) begin
                if (h.cyc == cyc - 1) begin
                    rsp_now = 1'b1; exp_err = 1'b1; exp_rdata = ERR_RDATA; exp_rid = h.aid;
                end
            end else if (h.cyc < cyc && $urandom_range(99) < p_rsp) begin
                r_data = $urandom;
                r_err  = ($urandom_range(7) == 0);
                bus.sbr_rvalid_i[h.tgt] = 1'b1;
                bus.sbr_rdata_i[h.tgt]  = r_data;
                bus.sbr_err_i[h.tgt]    = r_err;
                bus.sbr_rid_i[h.tgt]    = h.aid;
                rsp_now = 1'b1; exp_err = r_err; exp_rdata = r_data; exp_rid = h.aid;
            end
        end

        tgt     = ref_target(p_addr);
        allowed = (inflight.size() == 0)
               || (tgt == inflight[0].tgt && (inflight.size() < N_MAX_TRAN || rsp_now));
        exp_gnt = 1'b0;
        if (allowed) exp_gnt = (tgt == N_SBR) ? 1'b1 : gnts[tgt];
        exp_req = '0;
        if (pend && allowed && tgt < N_SBR) exp_req[tgt] = 1'b1;

        @(negedge clk);
        check_eq("mgr_gnt", 64'(bus.mgr_gnt_o), 64'(exp_gnt));
        check_eq("sbr_req", 64'(bus.sbr_req_o), 64'(exp_req));
        check_eq("rvalid", 64'(bus.mgr_rvalid_o), 64'(rsp_now));
        if (rsp_now) begin
            check_eq("rdata", 64'(bus.mgr_rdata_o), 64'(exp_rdata));
            check_eq("err", 64'(bus.mgr_err_o), 64'(exp_err));
            check_eq("rid", 64'(bus.mgr_rid_o), 64'(exp_rid));
        end
        if (pend) begin
            check_eq("bcast_addr", 64'(bus.sbr_addr_o[N_SBR-1]), 64'(p_addr));
            check_eq("bcast_wdata", 64'(bus.sbr_wdata_o[0]), 64'(p_wdata));
            check_eq("bcast_aid", 64'({bus.sbr_we_o[0], bus.sbr_be_o[1], bus.sbr_aid_o[1]}),
                     64'({p_we, p_be, p_aid}));
        end

        if (rsp_now) void'(inflight.pop_front());
        if (pend && exp_gnt) begin
            inflight.push_back('{tgt: tgt, aid: p_aid, cyc: cyc});
            n_txn++;
            $display("[TB] txn %0d cycle %0d addr=%08h we=%0d aid=%0d -> target %0d (outstanding %0d)",
                     n_txn, cyc, p_addr, p_we, p_aid, tgt, inflight.size());
            pend = 1'b0;
        end
        cyc++;
    endtask

    task automatic reset_pulse(input int ncyc);
        @(posedge clk); #1;
        rst  = 1'b1;
        pend = 1'b0;
        drive_idle();
        repeat (ncyc) @(posedge clk);
        #1;
        rst = 1'b0;
        inflight.delete();
        cyc += ncyc + 1;
        @(negedge clk);
        check_eq("rst_rvalid", 64'(bus.mgr_rvalid_o), 64'(0));
        check_eq("rst_err", 64'(bus.mgr_err_o), 64'(0));
        check_eq("rst_rdata", 64'(bus.mgr_rdata_o), 64'(0));
        check_eq("rst_rid", 64'(bus.mgr_rid_o), 64'(0));
        check_eq("rst_sbr_req", 64'(bus.sbr_req_o), 64'(0));
        cyc++;
    endtask

    initial begin
        set_rules(0);
        drive_idle();
        reset_pulse(3);

        // Mixed traffic over disjoint rules, including range edges and unmapped space.
        repeat (500) step(70, 70, 50, 0);
        // Saturate sbr1 with slow responses to exercise the outstanding limit.
        repeat (300) step(100, 100, 15, 1);
        // Mostly unmapped accesses, back-to-back error responses.
        repeat (200) step(90, 80, 60, 2);

        // Fill sbr1, then reset with transactions still in flight.
        repeat (20) step(0, 100, 100, 0);
        repeat (6) step(100, 100, 0, 1);
        reset_pulse(1);
        repeat (200) step(70, 70, 50, 0);

        // Overlapping rules: the lower-index rule must win.
        repeat (20) step(0, 100, 100, 0);
        set_rules(1);
        repeat (500) step(70, 70, 50, 0);
        repeat (20) step(0, 100, 100, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
